// File: rtl/seq_det_pkg.sv
// Shared definitions for the parameterised serial sequence detector.
// Holds the control FSM encoding and the default sizing constants.
package seq_det_pkg;

   localparam int DEF_PAT_W = 8;
   localparam int DEF_CNT_W = 16;

   typedef enum logic {
      DISABLED = 1'b0,
      ARMED    = 1'b1
   } state_e;

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign count = r_count;

endmodule : sat_counter

// File: rtl/seq_det_param.sv
// Runtime-configurable serial pattern detector with overlap control and a saturating match counter.
// Pattern is right-aligned: bit [len-1] is the oldest bit of the match, bit [0] the newest.
module seq_det_param
   import seq_det_pkg::*;
#(
   parameter  int PAT_W = DEF_PAT_W,
   parameter  int CNT_W = DEF_CNT_W,
   localparam int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic             in,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             clr_cnt,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt,
   output logic             armed,
   output logic             cfg_err
);

   state_e           r_state;
   logic [PAT_W-1:0] r_pat;
   logic [LEN_W-1:0] r_len;
   logic             r_ovl;
   logic [PAT_W-1:0] r_hist;
   logic [LEN_W-1:0] r_fill;
   logic             r_out;
   logic             r_cfg_err;

   logic [PAT_W-1:0] w_hist_next;
   logic [LEN_W-1:0] w_fill_inc;
   logic [PAT_W-1:0] w_mask;
   logic             w_len_bad;
   logic             w_shift;
   logic             w_match;

   assign w_len_bad   = (cfg_len == '0) || (32'(cfg_len) > PAT_W);
   assign w_shift     = (r_state == ARMED) && in_valid && !cfg_load;
   assign w_hist_next = (r_hist << 1) | {{(PAT_W-1){1'b0}}, in};
   assign w_fill_inc  = (r_fill < r_len) ? r_fill + LEN_W'(1) : r_fill;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         w_mask[i] = (i < int'(r_len));
      end
   end

   assign w_match = w_shift
                 && (((w_hist_next ^ r_pat) & w_mask) == '0)
                 && (w_fill_inc >= r_len);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= DISABLED;
         r_pat     <= '0;
         r_len     <= '0;
         r_ovl     <= 1'b0;
         r_hist    <= '0;
         r_fill    <= '0;
         r_out     <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_out <= 1'b0;
         if (cfg_load) begin
            r_pat     <= cfg_pattern;
            r_len     <= cfg_len;
            r_ovl     <= cfg_overlap;
            r_hist    <= '0;
            r_fill    <= '0;
            r_cfg_err <= w_len_bad;
            r_state   <= w_len_bad ? DISABLED : ARMED;
         end else if (w_shift) begin
            r_hist <= w_hist_next;
            // Non-overlapping mode restarts the fill so matched bits cannot be reused.
            r_fill <= (w_match && !r_ovl) ? '0 : w_fill_inc;
            r_out  <= w_match;
         end
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (w_match),
      .clr   (clr_cnt),
      .count (match_cnt)
   );

   assign out     = r_out;
   assign armed   = (r_state == ARMED);
   assign cfg_err = r_cfg_err;

endmodule : seq_det_param

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 8: maximum pattern length in bits, legal 2..32.
REQ-002 The block SHALL have parameter CNT_W, default 16: match counter width, legal 2..32.
REQ-003 The block SHALL have derived constant LEN_W = $clog2(PAT_W+1): width of the length field.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the serial bit on `in` is sampled this cycle.
REQ-007 The block SHALL have port in, input, 1 bit: serial data.
REQ-008 The block SHALL have port cfg_load, input, 1 bit: latch the configuration inputs this cycle.
REQ-009 The block SHALL have port cfg_pattern, input, PAT_W bits: pattern, right-aligned; bit [len-1] is the first bit received and bit [0] the last.
REQ-010 The block SHALL have port cfg_len, input, LEN_W bits: pattern length.
REQ-011 The block SHALL have port cfg_overlap, input, 1 bit: 1 = overlapping matches, 0 = non-overlapping.
REQ-012 The block SHALL have port clr_cnt, input, 1 bit: synchronous clear of match_cnt.
REQ-013 The block SHALL have port out, output, 1 bit: registered one-cycle match pulse.
REQ-014 The block SHALL have port match_cnt, output, CNT_W bits: saturating match count.
REQ-015 The block SHALL have port armed, output, 1 bit: a valid configuration is loaded.
REQ-016 The block SHALL have port cfg_err, output, 1 bit: the last cfg_load carried an illegal length.

Function
REQ-017 The block SHALL implement a two-state control FSM with states DISABLED and ARMED, where armed = (state == ARMED).
REQ-018 FSM transitions SHALL be:
- DISABLED->ARMED on cfg_load with 1 <= cfg_len <= PAT_W.
- Any state->DISABLED on cfg_load with cfg_len == 0 or cfg_len > PAT_W.
- The state SHALL be otherwise held.
REQ-019 On every cfg_load the block SHALL:
- latch pattern, length and overlap into internal registers;
- clear history and fill count;
- set cfg_err to the illegality of cfg_len.
REQ-020 In the cfg_load cycle, in_valid SHALL be ignored and out SHALL be 0 on the next cycle.
REQ-021 When ARMED and in_valid=1, the history register SHALL shift left, taking `in` into bit 0.
REQ-022 When ARMED and in_valid=1, the fill count SHALL increment, saturating at the latched length.
REQ-023 A match SHALL be declared when the low len bits of the updated history equal the low len bits of the latched pattern AND the updated fill >= len.
REQ-024 out SHALL be 1 for exactly the one cycle following the clock edge at which the matching bit was sampled, and 0 otherwise.
REQ-025 When in_valid=0, history and fill SHALL hold, and out SHALL be 0 on the next cycle.
REQ-026 In DISABLED, in_valid SHALL have no effect and out SHALL be 0.
REQ-027 On a match with overlap=1, history and fill SHALL be retained.
REQ-028 On a match with overlap=0, fill SHALL be cleared to 0 in the same edge, so that no bit of a matched pattern contributes to a later match.
REQ-029 On each match, match_cnt SHALL increment by 1 and saturate at 2^CNT_W-1 without wrapping.
REQ-030 clr_cnt SHALL set match_cnt to 0; when clr_cnt and a match occur in the same cycle, clr_cnt wins and match_cnt becomes 0.
REQ-031 clr_cnt SHALL NOT affect history, fill or out.
REQ-032 cfg_load SHALL NOT clear match_cnt.
REQ-033 With cfg_len=1, every sampled bit equal to pattern[0] SHALL produce a match in either overlap mode.

Reset
REQ-034 While rstn=0, regardless of clk:
- state SHALL be DISABLED;
- out, armed and cfg_err SHALL be 0;
- match_cnt SHALL be 0;
- history, fill and latched configuration SHALL be 0.
REQ-035 A reset asserted mid-pattern SHALL discard partial history, so that no match can complete from bits sampled before the reset.
REQ-036 After reset deassertion, the block SHALL remain DISABLED until a legal cfg_load.

Structure
REQ-037 Package seq_det_pkg SHALL hold the FSM state enum (DISABLED, ARMED) and the default PAT_W/CNT_W constants.
REQ-038 The saturating counter with clear SHALL be a sub-module sat_counter (parameter WIDTH; inputs inc and clr, with clr priority; output count).
REQ-039 History, fill and match comparison SHALL reside in seq_det_param.

Verification
REQ-040 Scenario overlap: load pattern=8'b00001011, len=4, overlap=1, then stream 1,0,1,1,0,1,1 continuous -> out pulses after bits 4 and 7; match_cnt=2.
REQ-041 Scenario non-overlap: same load with overlap=0 and the same stream -> out pulses after bit 4 only; match_cnt=1.
REQ-042 Scenario gaps: stream 1,0,1,1 with in_valid=0 inserted for 3 cycles between each bit -> exactly one out pulse, in the cycle after bit 4 is sampled.
REQ-043 Scenario illegal configuration: load with len=0, then len=9 (PAT_W=8) -> cfg_err=1, armed=0, no out for any stream; a following legal load -> cfg_err=0, armed=1.
REQ-044 Scenario saturation and clear: CNT_W=4, len=1, pattern bit 1, feed 20 ones -> match_cnt=15; assert clr_cnt together with a match -> match_cnt=0.
REQ-045 Scenario reset mid-pattern: stream 1,0,1, assert rstn=0 asynchronously, release, reload, send 1 -> no out; match_cnt=0.
